// File: rtl/layers_pkg.sv
// Shared types and constants for the layer frame arbiter: FSM state encoding,
// default terminator byte and a saturating counter helper.
package layers_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_PASS  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  localparam logic [7:0] ABORT_BYTE_DEFAULT = 8'hFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/layers_rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping
// from N-1 back to 0, reported both one-hot and as an index.
module layers_rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int               c;
    logic [IDX_W-1:0] ci;
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    c        = 0;
    ci       = '0;
    // k starts at 1 so the previous winner is checked last.
    for (int k = 1; k <= N; k++) begin
      c  = (int'(last_i) + k) % N;
      ci = IDX_W'(c);
      if (!valid_o && req_i[ci]) begin
        valid_o      = 1'b1;
        idx_o        = ci;
        onehot_o[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layers_frame_arbiter.sv
// Merges LAYER_COUNT byte-wide AXIS layer streams into one frame stream,
// granting whole frames round-robin and terminating frames that stall too long.
module layers_frame_arbiter
  import layers_pkg::*;
#(
  parameter int         LAYER_COUNT = 5,
  parameter logic [7:0] ABORT_BYTE  = ABORT_BYTE_DEFAULT
) (
  input  logic                     clk_core,
  input  logic                     clk_core_resn,
  input  logic [LAYER_COUNT*8-1:0] s_axis_tdata,
  input  logic [LAYER_COUNT*8-1:0] s_axis_tdest,
  input  logic [LAYER_COUNT-1:0]   s_axis_tvalid,
  input  logic [LAYER_COUNT-1:0]   s_axis_tlast,
  output logic [LAYER_COUNT-1:0]   s_axis_tready,
  output logic [7:0]               m_axis_tdata,
  output logic [7:0]               m_axis_tdest,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [LAYER_COUNT-1:0]   cfg_suppress,
  input  logic [15:0]              cfg_timeout,
  output logic [LAYER_COUNT-1:0]   stat_frame_done,
  output logic [LAYER_COUNT-1:0]   stat_abort,
  output logic                     status_busy,
  output arb_state_e               dbg_state_o
);

  localparam int IDX_W = (LAYER_COUNT > 1) ? $clog2(LAYER_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(LAYER_COUNT - 1);

  // Handshake: a beat moves on any edge where valid and ready are both high;
  // a source holds tdata/tdest/tlast stable while valid is high and ready is low.
  arb_state_e             state_q;
  logic [IDX_W-1:0]       gnt_q, last_q;
  logic [LAYER_COUNT-1:0] gnt_oh_q;
  logic [15:0]            stall_q;
  logic [7:0]             m_data_q, m_dest_q;
  logic                   m_last_q, m_valid_q, busy_q;
  logic [LAYER_COUNT-1:0] done_q, abort_q;

  logic [LAYER_COUNT-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  layers_rr_pick #(.N(LAYER_COUNT), .IDX_W(IDX_W)) u_pick (
    .req_i    (s_axis_tvalid & ~cfg_suppress),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  logic       out_free, in_pass, g_valid, g_last, accept, timeout_hit;
  logic [7:0] g_data, g_dest;

  always_comb begin
    out_free    = !m_valid_q || m_axis_tready;
    in_pass     = (state_q == ARB_PASS);
    g_valid     = s_axis_tvalid[gnt_q];
    g_last      = s_axis_tlast[gnt_q];
    g_data      = s_axis_tdata[gnt_q*8 +: 8];
    g_dest      = s_axis_tdest[gnt_q*8 +: 8];
    accept      = in_pass && g_valid && out_free;
    // Compared live so a new limit applies to the count already accumulated.
    timeout_hit = (cfg_timeout != 16'd0) && (stall_q >= cfg_timeout);
  end

  assign s_axis_tready   = (in_pass && out_free) ? gnt_oh_q : '0;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tdest    = m_dest_q;
  assign m_axis_tlast    = m_last_q;
  assign m_axis_tvalid   = m_valid_q;
  assign stat_frame_done = done_q;
  assign stat_abort      = abort_q;
  assign status_busy     = busy_q;
  assign dbg_state_o     = state_q;

  always_ff @(posedge clk_core or negedge clk_core_resn) begin
    if (!clk_core_resn) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_oh_q  <= '0;
      last_q    <= LAST_RST;
      stall_q   <= '0;
      m_data_q  <= '0;
      m_dest_q  <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= '0;
      abort_q   <= '0;
    end else begin
      done_q  <= '0;
      abort_q <= '0;
      if (m_axis_tready) m_valid_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_q    <= pick_idx;
            gnt_oh_q <= pick_oh;
            stall_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (accept) begin
            m_data_q  <= g_data;
            m_dest_q  <= g_dest;
            m_last_q  <= g_last;
            m_valid_q <= 1'b1;
            stall_q   <= '0;
            if (g_last) begin
              done_q  <= gnt_oh_q;
              last_q  <= gnt_q;
              busy_q  <= 1'b0;
              state_q <= ARB_IDLE;
            end
          end else if (timeout_hit) begin
            state_q <= ARB_ABORT;
          end else if (!g_valid && out_free) begin
            stall_q <= sat_inc16(stall_q);
          end
        end
        ARB_ABORT: begin
          if (out_free) begin
            m_data_q  <= ABORT_BYTE;
            m_dest_q  <= 8'(gnt_q) + 8'd1;
            m_last_q  <= 1'b1;
            m_valid_q <= 1'b1;
            abort_q   <= gnt_oh_q;
            last_q    <= gnt_q;
            busy_q    <= 1'b0;
            state_q   <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layers_frame_arbiter.sv
// Self-checking bench for layers_frame_arbiter: queue-driven layer sources, an
// output monitor and a frame-level round-robin model producing the expected stream.
module tb_layers_frame_arbiter;
  import layers_pkg::*;

  localparam int LC = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [LC*8-1:0] s_tdata, s_tdest;
  logic [LC-1:0]   s_tvalid, s_tlast, s_tready, sup;
  logic [7:0]      m_tdata, m_tdest;
  logic            m_tlast, m_valid, m_ready, busy;
  logic [15:0]     tmo;
  logic [LC-1:0]   stat_done, stat_abort;
  arb_state_e      dbg_state;

  always #5 clk = ~clk;

  layers_frame_arbiter #(.LAYER_COUNT(LC), .ABORT_BYTE(8'hFF)) dut (
    .clk_core(clk), .clk_core_resn(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tdest(s_tdest), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tdest(m_tdest), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .cfg_suppress(sup), .cfg_timeout(tmo),
    .stat_frame_done(stat_done), .stat_abort(stat_abort), .status_busy(busy),
    .dbg_state_o(dbg_state)
  );

  logic [8:0]  src_q[LC][$];   // driver queues {tlast, tdata}
  logic [8:0]  mdl_q[LC][$];   // model copy of complete frames
  logic [16:0] got_q[$];       // {tdest, tlast, tdata}
  logic [16:0] exp_q[$];
  int          got_cyc[$], done_q[$], abort_q[$], exp_done[$];
  int          model_last, ready_mode, cyc, n_checks, n_fail;
  logic [LC-1:0] s_fire;
  bit          tog;

  // Clock/reset and driver: pops fired beats, then presents each queue head.
  initial begin
    rst_n = 1'b0; sup = '0; tmo = '0; m_ready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tdest = '0;
    ready_mode = 0; tog = 1'b0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < LC; i++)
        if (s_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      #1;
      for (int i = 0; i < LC; i++) begin
        s_tvalid[i]       = src_q[i].size() > 0;
        s_tdata[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
        s_tlast[i]        = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
        s_tdest[i*8 +: 8] = 8'(i);
      end
      tog = ~tog;
      case (ready_mode)
        1:       m_ready = tog;
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: records output beats and pulses, checks stability and tready rules.
  initial begin
    logic [17:0] prev_beat;
    bit          prev_stall;
    prev_beat = '0; prev_stall = 0; cyc = 0; s_fire = '0;
    forever begin
      @(negedge clk);
      cyc++;
      s_fire = s_tvalid & s_tready;
      if (rst_n) begin
        if (m_valid && m_ready) begin
          got_q.push_back({m_tdest, m_tlast, m_tdata});
          got_cyc.push_back(cyc);
        end
        for (int i = 0; i < LC; i++) begin
          if (stat_done[i]) done_q.push_back(i);
          if (stat_abort[i]) abort_q.push_back(i);
        end
        if (prev_stall) begin
          n_checks++;
          if ({m_valid, m_tdest, m_tlast, m_tdata} !== prev_beat) begin
            n_fail++;
            $display("FAIL hold_stable got %h required %h", {m_valid, m_tdest, m_tlast, m_tdata}, prev_beat);
          end
        end
        if (s_tready != '0) begin
          n_checks++;
          if ($countones(s_tready) != 1 || (m_valid && !m_ready)) begin
            n_fail++;
            $display("FAIL tready_rule tready=%b m_valid=%b m_ready=%b required one-hot and output free",
                     s_tready, m_valid, m_ready);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_beat  = {m_valid, m_tdest, m_tlast, m_tdata};
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_frame(input int layer, input int len);
    logic [8:0] b;
    for (int j = 0; j < len; j++) begin
      b = {(j == len - 1), 8'($urandom_range(0, 255))};
      src_q[layer].push_back(b);
      mdl_q[layer].push_back(b);
    end
  endtask

  // Frame-level model: whole frames leave in round-robin order from last winner.
  task automatic model_run(input logic [LC-1:0] msk);
    bit found; int c; logic [8:0] b;
    do begin
      found = 0;
      for (int k = 1; k <= LC && !found; k++) begin
        c = (model_last + k) % LC;
        if (!msk[c] && mdl_q[c].size() > 0) begin
          found = 1; model_last = c; exp_done.push_back(c);
          do begin
            b = mdl_q[c].pop_front();
            exp_q.push_back({8'(c), b});
          end while (!b[8]);
        end
      end
    end while (found);
  endtask

  task automatic wait_beats(input int n, input int budget, output bit ok);
    int t = 0;
    while (got_q.size() < n && t < budget) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    ok = (got_q.size() >= n);
  endtask

  function automatic longint seq_sig(input int q[$]);
    longint s = 0;
    foreach (q[k]) s = s * 17 + q[k] + 1;
    return s;
  endfunction

  task automatic clear_all();
    got_q.delete(); got_cyc.delete(); done_q.delete(); abort_q.delete();
    exp_q.delete(); exp_done.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({m_valid, m_tlast, m_tdata, m_tdest, s_tready, stat_done, stat_abort, busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero outputs required all zero");
    end
    n_checks++;
    if (dbg_state !== ARB_IDLE) begin
      n_fail++; $display("FAIL reset_state got %0d required %0d", dbg_state, ARB_IDLE);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    model_last = LC - 1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({m_valid, busy, s_tready} !== '0) begin
      n_fail++; $display("FAIL post_reset_idle got valid=%b busy=%b tready=%b required 0", m_valid, busy, s_tready);
    end
  endtask

  task automatic test_two_layers();
    bit ok;
    clear_all(); ready_mode = 0;
    load_frame(0, 4); load_frame(2, 4);
    model_run('0);
    wait_beats(exp_q.size(), 100, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL two_layers beat_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL two_layers beat%0d got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (seq_sig(done_q) != seq_sig(exp_done) || done_q.size() != 2) begin
      n_fail++; $display("FAIL two_layers frame_done got %0d pulses required %0d", done_q.size(), exp_done.size());
    end
  endtask

  task automatic test_rr_fairness();
    bit ok;
    clear_all(); ready_mode = 0;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < LC; i++) load_frame(i, 1);
    model_run('0);
    wait_beats(exp_q.size(), 200, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rr_fairness beat_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL rr_fairness beat%0d got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (seq_sig(done_q) != seq_sig(exp_done)) begin
      n_fail++; $display("FAIL rr_fairness grant_order got %0d pulses required %0d", done_q.size(), exp_done.size());
    end
  endtask

  task automatic test_backpressure(input int mode, input int rounds);
    bit ok;
    clear_all(); ready_mode = mode;
    if (rounds == 0) load_frame(4, 16);
    for (int r = 0; r < rounds; r++)
      for (int i = 0; i < LC; i++)
        if ($urandom_range(0, 2) != 0) load_frame(i, $urandom_range(1, 6));
    model_run('0);
    wait_beats(exp_q.size(), exp_q.size() * 10 + 100, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL backpressure mode%0d beat_count got %0d required %0d", mode, got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL backpressure mode%0d beat%0d got %h required %h", mode, k, got_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (seq_sig(done_q) != seq_sig(exp_done)) begin
      n_fail++; $display("FAIL backpressure mode%0d frame_done got %0d pulses required %0d", mode, done_q.size(), exp_done.size());
    end
    ready_mode = 0;
  endtask

  // Starves a layer after nbytes; returns output-cycle gap before the terminator.
  task automatic run_timeout(input int layer, input int nbytes, input int limit, output int gap);
    bit ok; logic [16:0] want;
    clear_all(); ready_mode = 0; tmo = 16'(limit);
    for (int j = 0; j < nbytes; j++) begin
      want = {8'(layer), 1'b0, 8'($urandom_range(0, 255))};
      src_q[layer].push_back(want[8:0]);
      exp_q.push_back(want);
    end
    exp_q.push_back({8'(layer + 1), 1'b1, 8'hFF});
    wait_beats(exp_q.size(), limit + 60, ok);
    gap = (got_q.size() > nbytes) ? got_cyc[nbytes] - got_cyc[nbytes - 1] : 0;
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL timeout%0d beat_count got %0d required %0d", limit, got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL timeout%0d beat%0d got %h required %h", limit, k, got_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (abort_q.size() != 1 || done_q.size() != 0 || (abort_q.size() > 0 && abort_q[0] != layer)) begin
      n_fail++; $display("FAIL timeout%0d stat_abort got %0d aborts %0d dones required one abort on layer %0d",
                         limit, abort_q.size(), done_q.size(), layer);
    end
    n_checks++;
    if (gap <= limit) begin
      n_fail++; $display("FAIL timeout%0d gap got %0d required more than %0d", limit, gap, limit);
    end
    tmo = '0;
  endtask

  task automatic test_timeout();
    int gap10, gap3;
    run_timeout(1, 3, 10, gap10);
    run_timeout(3, 2, 3, gap3);
    n_checks++;
    if (gap10 - gap3 != 7) begin
      n_fail++; $display("FAIL timeout_scaling got gap difference %0d required 7", gap10 - gap3);
    end
    model_last = 3;
  endtask

  task automatic test_suppress();
    bit ok;
    clear_all(); ready_mode = 0; sup = 5'b00010;
    load_frame(1, 4); load_frame(3, 8);
    model_run(5'b00010);
    wait_beats(2, 50, ok);
    sup = 5'b01010;
    wait_beats(exp_q.size(), 60, ok);
    repeat (20) @(negedge clk);
    n_checks++;
    if (got_q.size() != exp_q.size() || busy !== 1'b0) begin
      n_fail++; $display("FAIL suppress beat_count got %0d busy=%b required %0d busy=0", got_q.size(), busy, exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL suppress beat%0d got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
    clear_all(); sup = '0;
    model_run('0);
    wait_beats(exp_q.size(), 60, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size() || seq_sig(done_q) != seq_sig(exp_done)) begin
      n_fail++; $display("FAIL suppress_release beat_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL suppress_release beat%0d got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_all(); ready_mode = 1;
    for (int j = 0; j < 16; j++) src_q[2].push_back({(j == 15), 8'(j + 8'h40)});
    wait_beats(4, 100, ok);
    @(posedge clk); #2 rst_n = 1'b0;
    for (int i = 0; i < LC; i++) begin src_q[i].delete(); mdl_q[i].delete(); end
    @(negedge clk);
    n_checks++;
    if ({m_valid, m_tlast, m_tdata, m_tdest, s_tready, stat_done, stat_abort, busy} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs got valid=%b last=%b data=%h dest=%h tready=%b busy=%b required all 0",
                         m_valid, m_tlast, m_tdata, m_tdest, s_tready, busy);
    end
    @(posedge clk); #2 rst_n = 1'b1;
    model_last = LC - 1; ready_mode = 0;
    clear_all();
    load_frame(3, 3); load_frame(0, 2);
    model_run('0);
    wait_beats(exp_q.size(), 80, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL reset_mid beat_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) if (k < got_q.size()) begin
      n_checks++;
      if (got_q[k] !== exp_q[k]) begin
        n_fail++; $display("FAIL reset_mid beat%0d got %h required %h", k, got_q[k], exp_q[k]);
      end
    end
    n_checks++;
    if (done_q.size() == 0 || done_q[0] != 0) begin
      n_fail++; $display("FAIL reset_mid first_grant got %0d pulses first=%0d required layer 0",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; model_last = LC - 1;
    test_reset();
    test_two_layers();
    test_rr_fairness();
    test_backpressure(1, 0);
    test_backpressure(2, 3);
    test_timeout();
    test_suppress();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layers_frame_arbiter.md
LAYERS_FRAME_ARBITER -- requirements
Module: layers_frame_arbiter

Interface
REQ-001 SHALL have parameter LAYER_COUNT, default 5, number of layer AXIS slave ports (1..16).
REQ-002 SHALL have parameter ABORT_BYTE, default 8'hFF, tdata emitted on the forced-terminator beat.
REQ-003 SHALL have port clk_core  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clk_core_resn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports s_axis_tdata  in  LAYER_COUNT*8  and s_axis_tdest  in  LAYER_COUNT*8, per-layer frame byte and layer ID; layer i occupies bits [i*8+7:i*8].
REQ-006 SHALL have ports s_axis_tvalid and s_axis_tlast  in  LAYER_COUNT, and s_axis_tready  out  LAYER_COUNT, per-layer handshake.
REQ-007 SHALL have ports m_axis_tdata  out  8, m_axis_tdest  out  8, m_axis_tlast  out  1, m_axis_tvalid  out  1, m_axis_tready  in  1, merged stream to the frame FIFO.
REQ-008 SHALL have port cfg_suppress  in  LAYER_COUNT, where 1 excludes a layer from new grants.
REQ-009 SHALL have port cfg_timeout  in  16, mid-frame stall limit in cycles; 0 disables the limit.
REQ-010 SHALL have ports stat_frame_done and stat_abort  out  LAYER_COUNT, one-cycle pulses per layer.
REQ-011 SHALL have port status_busy  out  1, high while a grant is held.

Function
REQ-012 SHALL use states IDLE, PASS and ABORT.
REQ-013 IDLE: SHALL grant the first layer with tvalid=1 and cfg_suppress=0, searching round-robin from last_grant+1 and wrapping at LAYER_COUNT-1 to 0, and SHALL enter PASS on the next cycle.
REQ-014 PASS: s_axis_tready[g] SHALL equal (!m_axis_tvalid | m_axis_tready); all other tready bits SHALL be 0.
REQ-015 SHALL register each accepted beat (tdata, tdest, tlast) into the output register, giving one cycle of latency and 100% throughput under continuous tready.
REQ-016 SHALL hold m_axis_* stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 On acceptance of a beat with tlast=1, SHALL pulse stat_frame_done[g], update last_grant=g and return to IDLE; a new grant MAY be issued in the following cycle.
REQ-018 SHALL hold the grant until tlast; a cfg_suppress change mid-frame SHALL NOT release the grant.
REQ-019 In PASS, the stall counter SHALL increment each cycle in which s_axis_tvalid[g]=0 and the output register is free, and SHALL clear on any accepted beat.
REQ-020 When the stall counter equals cfg_timeout (nonzero), SHALL enter ABORT.
REQ-021 ABORT: SHALL load one beat {ABORT_BYTE, tdest=g+1, tlast=1} once the output register is free, pulse stat_abort[g], set last_grant=g and go to IDLE; s_axis_tready SHALL be 0 throughout ABORT.
REQ-022 The stall counter SHALL saturate at 16'hFFFF.
REQ-023 A cfg_timeout change mid-frame SHALL take effect immediately, compared against the current count.
REQ-024 A single-beat frame (tvalid and tlast on the first beat) SHALL be passed and terminate the grant normally.

Reset
REQ-025 While clk_core_resn=0, SHALL set state=IDLE, last_grant=LAYER_COUNT-1, stall counter=0, and m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, s_axis_tready, stat_* and status_busy all to 0.
REQ-026 Reset asserted mid-frame SHALL discard the output register content; no partial-frame completion SHALL be attempted after release.

Structure
REQ-027 SHALL place the state enum (ARB_IDLE, ARB_PASS, ARB_ABORT) and ABORT_BYTE default in the shared layers package.
REQ-028 SHALL place the round-robin priority search in sub-module layers_rr_pick (req, last-grant pointer -> one-hot/index, valid), which is purely combinational.

Verification
REQ-029 Layers 0 and 2 each present a 4-byte frame simultaneously after reset -> output is layer 0's 4 bytes then layer 2's 4 bytes, tlast only on bytes 4 and 8, stat_frame_done[0] then [2] pulse once.
REQ-030 All 5 layers continuously valid with 1-byte frames -> grant order 0,1,2,3,4,0...; no layer starves.
REQ-031 m_axis_tready toggling 1010... during a 16-byte frame -> output bytes identical and in order, with no duplicates or losses.
REQ-032 cfg_timeout=10 and layer 1 drops tvalid after 3 bytes -> after 10 stalled cycles, beat {8'hFF, tdest=2, tlast=1} is emitted and stat_abort[1] pulses.
REQ-033 cfg_suppress=5'b00010 with layers 1 and 3 valid -> only layer 3 is granted; suppress raised mid-frame on layer 3 -> frame completes.
REQ-034 clk_core_resn pulsed low mid-frame -> all outputs are 0 during reset, and the first post-reset grant goes to layer 0.
